fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, address width.
REQ-002 Parameter DATA_W, default 16, instruction width.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before fault, range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 pc_in  input  ADDR_W  current program counter value.
REQ-007 fetch_req  input  1  controller request to fetch at pc_in.
REQ-008 flush  input  1  abort any fetch and discard any held instruction.
REQ-009 mem_addr  output  ADDR_W  instruction memory read address.
REQ-010 mem_rd  output  1  memory read strobe.
REQ-011 mem_ready  input  1  memory read data valid.
REQ-012 mem_data  input  DATA_W  memory read data.
REQ-013 pc_enable  output  1  one-cycle increment pulse to the program counter.
REQ-014 ir_out  output  DATA_W  latched instruction.
REQ-015 ir_valid  output  1  ir_out holds an unconsumed instruction.
REQ-016 ir_ready  input  1  consumer accepts ir_out.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 fault  output  1  sticky memory-timeout flag.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
REQ-020 IDLE, fetch_req=1: mem_addr<=pc_in; go to REQ. Otherwise stay in IDLE.
REQ-021 REQ: mem_rd<=1; clear the timeout counter; go to WAIT.
REQ-022 WAIT, mem_ready=1: ir_out<=mem_data; mem_rd<=0; pc_enable=1 for exactly that next cycle; ir_valid<=1; go to HOLD.
REQ-023 WAIT, mem_ready=0: the timeout counter increments.
REQ-024 When the timeout counter reaches TIMEOUT, mem_rd<=0 and fault<=1, and the FSM goes to FAULT.
REQ-025 mem_addr is stable from REQ until mem_ready is sampled; later pc_in changes are ignored.
REQ-026 HOLD, ir_ready=1: ir_valid<=0.
REQ-027 HOLD, ir_ready=1 and fetch_req=1 in the same cycle: mem_addr<=pc_in and go to REQ (back-to-back fetch).
REQ-028 HOLD, ir_ready=1 and fetch_req=0: go to IDLE.
REQ-029 HOLD, ir_ready=0: ir_valid and ir_out are held.
REQ-030 FAULT stays in FAULT with mem_rd=0 and fault=1 until flush or reset.
REQ-031 flush in any state: next state IDLE; mem_rd<=0; ir_valid<=0; fault<=0; no pc_enable.
REQ-032 flush and mem_ready in the same cycle: flush wins; data discarded; pc_enable stays 0.
REQ-033 mem_ready outside WAIT is ignored.
REQ-034 fetch_req outside IDLE and HOLD is ignored.
REQ-035 Minimum latency, fetch_req to ir_valid: 3 cycles with mem_ready already high on entry to WAIT.
REQ-036 pc_enable is never high for more than one consecutive cycle.

Reset
REQ-037 rst low immediately forces: state IDLE, mem_addr=0, mem_rd=0, pc_enable=0, ir_out=0, ir_valid=0, fault=0, busy=0, timeout counter=0.
REQ-038 Reset asserted mid-fetch abandons the fetch without a pc_enable pulse.
REQ-039 After rst returns high, the first fetch_req is honoured on the next rising edge.

Structure
REQ-040 FSM state encodings, ADDR_W, and DATA_W defaults are placed in the shared package cpu_pkg.
REQ-041 The timeout counter is the sub-module fetch_timer, with clear, enable, and expired ports and parameter TIMEOUT.
REQ-042 All outputs are registered except busy, which is decoded from the state.

Verification
REQ-043 Basic fetch: pc_in=0x0010, fetch_req pulse, mem_ready high 1 cycle after mem_rd with mem_data=0xA5C3 -> mem_addr=0x0010; ir_out=0xA5C3; ir_valid=1; exactly one pc_enable pulse.
REQ-044 Back-pressure: ir_ready=0 for 5 cycles -> ir_valid and ir_out held; no second mem_rd. Then ir_ready=1 with fetch_req=1 and pc_in=0x0011 -> REQ entered the next cycle with mem_addr=0x0011.
REQ-045 Timeout with TIMEOUT=4 and mem_ready held 0 -> fault=1 after 4 WAIT cycles; mem_rd=0; no pc_enable. Then flush -> fault=0 and state IDLE.
REQ-046 Flush collision: flush and mem_ready asserted together with mem_data=0x1234 -> ir_valid=0; ir_out unchanged; pc_enable=0.
REQ-047 Async reset: rst low mid-clock during WAIT -> mem_rd=0 and busy=0 before the next edge; no pc_enable after rst is released.
REQ-048 Wrap-around: pc_in=0xFFFF fetch -> mem_addr=0xFFFF; normal completion; one pc_enable pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: state encodings and
// default bus widths.
package cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Memory wait timer. Counts cycles spent waiting for the memory and flags
// the cycle whose increment brings the count up to TIMEOUT, so the owner
// can leave its wait state on exactly the TIMEOUT-th waiting cycle.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;

    // Wait-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read per fetch request, latches
// the returned instruction, pulses the PC increment once per completed fetch
// and raises a sticky fault when the memory does not answer in time.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              pc_enable,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              fault
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_rd_reg, mem_rd_next;
    logic              pc_enable_reg, pc_enable_next;
    logic [DATA_W-1:0] ir_out_reg, ir_out_next;
    logic              ir_valid_reg, ir_valid_next;
    logic              fault_reg, fault_next;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // The timer restarts on every new request and on flush, and only counts
    // WAIT cycles in which the memory has not answered.
    assign timer_clear  = flush || (state_reg == ST_REQ);
    assign timer_enable = !flush && (state_reg == ST_WAIT) && !mem_ready;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            mem_addr_reg  <= '0;
            mem_rd_reg    <= 1'b0;
            pc_enable_reg <= 1'b0;
            ir_out_reg    <= '0;
            ir_valid_reg  <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_addr_reg  <= mem_addr_next;
            mem_rd_reg    <= mem_rd_next;
            pc_enable_reg <= pc_enable_next;
            ir_out_reg    <= ir_out_next;
            ir_valid_reg  <= ir_valid_next;
            fault_reg     <= fault_next;
        end
    end

    // Next-state and next-output decode; flush overrides every state.
    always_comb begin
        state_next     = state_reg;
        mem_addr_next  = mem_addr_reg;
        mem_rd_next    = mem_rd_reg;
        pc_enable_next = 1'b0;
        ir_out_next    = ir_out_reg;
        ir_valid_next  = ir_valid_reg;
        fault_next     = fault_reg;

        if (flush) begin
            state_next    = ST_IDLE;
            mem_rd_next   = 1'b0;
            ir_valid_next = 1'b0;
            fault_next    = 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (fetch_req) begin
                        mem_addr_next = pc_in;
                        state_next    = ST_REQ;
                    end
                end
                ST_REQ: begin
                    mem_rd_next = 1'b1;
                    state_next  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        ir_out_next    = mem_data;
                        mem_rd_next    = 1'b0;
                        pc_enable_next = 1'b1;
                        ir_valid_next  = 1'b1;
                        state_next     = ST_HOLD;
                    end else if (timer_expired) begin
                        mem_rd_next = 1'b0;
                        fault_next  = 1'b1;
                        state_next  = ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (ir_ready) begin
                        ir_valid_next = 1'b0;
                        if (fetch_req) begin
                            mem_addr_next = pc_in;
                            state_next    = ST_REQ;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    mem_rd_next = 1'b0;
                    fault_next  = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_rd    = mem_rd_reg;
    assign pc_enable = pc_enable_reg;
    assign ir_out    = ir_out_reg;
    assign ir_valid  = ir_valid_reg;
    assign fault     = fault_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
